hssi_tc_mailbox_resp: RTL and testbench

HSSI_TC_MAILBOX_RESP -- requirements
Module: hssi_tc_mailbox_resp

---
 rtl/hssi_tc_mailbox_resp_pkg.sv | 50 +++++
 rtl/hssi_tc_mailbox_resp_if.sv | 32 +++
 rtl/hssi_tc_mailbox_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_hssi_tc_mailbox_resp.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_tc_mailbox_resp_pkg.sv
// ---------------------------------------------------------------------------
// hssi_tc_mailbox_resp_pkg
//   Shared definitions for the HSSI traffic-controller mailbox responder:
//   mailbox byte offsets, command encodings, CMD status bit positions,
//   the read pattern returned after a timeout, and the FSM state type.
// ---------------------------------------------------------------------------
package hssi_tc_mailbox_resp_pkg;

    // Mailbox byte offsets on the CSR side.
    localparam logic [3:0] OFF_CMD     = 4'h0;
    localparam logic [3:0] OFF_ADDRESS = 4'h4;
    localparam logic [3:0] OFF_RDDATA  = 4'h8;
    localparam logic [3:0] OFF_WRDATA  = 4'hC;

    // Command encodings carried in CMD[1:0].
    typedef enum logic [1:0] {
        CMD_NOOP    = 2'h0,
        CMD_RD      = 2'h1,
        CMD_WR      = 2'h2,
        CMD_ILLEGAL = 2'h3
    } cmd_e;

    // Status bit positions within a CMD read.
    localparam int STAT_ACK_BIT  = 2;
    localparam int STAT_BUSY_BIT = 3;
    localparam int STAT_ERR_BIT  = 4;

    // RDDATA contents after a read that timed out.
    localparam logic [31:0] TIMEOUT_RDDATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } state_e;

    // Assemble the CMD readback word {27'b0, err, busy, ack, cmd}.
    function automatic logic [31:0] cmd_status(cmd_e cmd, logic ack, logic busy, logic err);
        logic [31:0] s;
        s                = '0;
        s[1:0]           = cmd;
        s[STAT_ACK_BIT]  = ack;
        s[STAT_BUSY_BIT] = busy;
        s[STAT_ERR_BIT]  = err;
        return s;
    endfunction

endpackage

// File: rtl/hssi_tc_mailbox_resp_if.sv
// ---------------------------------------------------------------------------
// hssi_tc_mailbox_resp_if
//   Traffic-controller register bus between the mailbox (master) and the
//   traffic controller (slave).
//     tc_rd / tc_wr     : request strobes, held until tc_waitrequest is low
//     tc_addr           : TC word address
//     tc_wrdata         : write data
//     tc_waitrequest    : slave stall
//     tc_rddata         : read data
//     tc_rddata_valid   : qualifies tc_rddata
// ---------------------------------------------------------------------------
interface hssi_tc_mailbox_resp_if #(
    parameter int TC_ADDR_W = 16
);
    logic                 tc_rd;
    logic                 tc_wr;
    logic [TC_ADDR_W-1:0] tc_addr;
    logic [31:0]          tc_wrdata;
    logic                 tc_waitrequest;
    logic [31:0]          tc_rddata;
    logic                 tc_rddata_valid;

    modport master (
        output tc_rd, tc_wr, tc_addr, tc_wrdata,
        input  tc_waitrequest, tc_rddata, tc_rddata_valid
    );

    modport slave (
        input  tc_rd, tc_wr, tc_addr, tc_wrdata,
        output tc_waitrequest, tc_rddata, tc_rddata_valid
    );
endinterface

// File: rtl/hssi_tc_mailbox_resp.sv
// ---------------------------------------------------------------------------
// hssi_tc_mailbox_resp
//   CSR mailbox that turns software commands into single traffic-controller
//   register accesses.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     csr_wr/csr_rd : mailbox write / read strobes
//     csr_addr      : byte offset (0x0 CMD, 0x4 ADDRESS, 0x8 RDDATA, 0xC WRDATA)
//     csr_wrdata    : CSR write data
//     csr_rddata    : CSR read data, valid with csr_rdvalid one cycle after csr_rd
//     tc            : traffic-controller bus (master side)
//   CMD readback is {27'b0, err, busy, ack, cmd}. busy is high exactly while
//   the FSM is outside IDLE, so all software writes are accepted only in IDLE.
// ---------------------------------------------------------------------------
module hssi_tc_mailbox_resp
    import hssi_tc_mailbox_resp_pkg::*;
#(
    parameter int TC_ADDR_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csr_wr,
    input  logic                          csr_rd,
    input  logic [3:0]                    csr_addr,
    input  logic [31:0]                   csr_wrdata,
    output logic [31:0]                   csr_rddata,
    output logic                          csr_rdvalid,
    hssi_tc_mailbox_resp_if.master        tc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    cmd_e             cmd_q;
    logic [31:0]      address_q;
    logic [31:0]      wrdata_q;
    logic [31:0]      rddata_q;
    logic             ack_q, busy_q, err_q;

    cmd_e             wr_cmd;
    logic             cmd_wr_ok;
    logic             timed_state;
    logic             timeout_fire;

    assign wr_cmd      = cmd_e'(csr_wrdata[1:0]);
    assign cmd_wr_ok   = csr_wr && (csr_addr == OFF_CMD) && !busy_q;
    assign timed_state = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ) ||
                         (state_q == ST_RD_WAIT);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A completing handshake wins over a timeout that
    // expires in the same cycle.
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state_q;
        timeout_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_wr_ok) begin
                    if (wr_cmd == CMD_RD)      state_nxt = ST_RD_REQ;
                    else if (wr_cmd == CMD_WR) state_nxt = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (!tc.tc_waitrequest) begin
                    state_nxt = ST_RD_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt    = ST_DONE;
                    timeout_fire = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (!tc.tc_waitrequest) begin
                    state_nxt = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt    = ST_DONE;
                    timeout_fire = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (tc.tc_rddata_valid) begin
                    state_nxt = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt    = ST_DONE;
                    timeout_fire = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Timeout counter: cleared on every state change, counts only while
    // waiting on the traffic controller.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_nxt != state_q) begin
            cnt_q <= '0;
        end else if (timed_state) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Mailbox registers and status bits
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= CMD_NOOP;
            address_q <= '0;
            wrdata_q  <= '0;
            rddata_q  <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // RDDATA is read-only from software; unmapped offsets are dropped.
            if (csr_wr && !busy_q) begin
                case (csr_addr)
                    OFF_ADDRESS: address_q <= csr_wrdata;
                    OFF_WRDATA:  wrdata_q  <= csr_wrdata;
                    OFF_CMD: begin
                        cmd_q <= wr_cmd;
                        case (wr_cmd)
                            CMD_RD, CMD_WR: begin
                                ack_q  <= 1'b0;
                                err_q  <= 1'b0;
                                busy_q <= 1'b1;
                            end
                            CMD_ILLEGAL: begin
                                ack_q <= 1'b1;
                                err_q <= 1'b1;
                            end
                            default: begin
                                ack_q <= 1'b0;
                                err_q <= 1'b0;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            // Read data is only accepted while a read is outstanding.
            if (state_q == ST_RD_WAIT && tc.tc_rddata_valid) begin
                rddata_q <= tc.tc_rddata;
            end

            if (timeout_fire) begin
                err_q <= 1'b1;
                if (state_q != ST_WR_REQ) begin
                    rddata_q <= TIMEOUT_RDDATA;
                end
            end

            if (state_q == ST_DONE) begin
                ack_q  <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Traffic-controller outputs. Strobes are registered from the next state
    // so they are high for exactly the cycles spent in the request states.
    // Address and data are latched on leaving IDLE; ADDRESS/WRDATA cannot
    // change afterwards because writes are blocked while busy.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc.tc_rd     <= 1'b0;
            tc.tc_wr     <= 1'b0;
            tc.tc_addr   <= '0;
            tc.tc_wrdata <= '0;
        end else begin
            tc.tc_rd <= (state_nxt == ST_RD_REQ);
            tc.tc_wr <= (state_nxt == ST_WR_REQ);
            if (state_q == ST_IDLE && state_nxt != ST_IDLE) begin
                tc.tc_addr   <= address_q[TC_ADDR_W-1:0];
                tc.tc_wrdata <= wrdata_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // CSR read port: one cycle latency, returns pre-edge register values.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rddata  <= '0;
            csr_rdvalid <= 1'b0;
        end else begin
            csr_rdvalid <= csr_rd;
            if (csr_rd) begin
                case (csr_addr)
                    OFF_CMD:     csr_rddata <= cmd_status(cmd_q, ack_q, busy_q, err_q);
                    OFF_ADDRESS: csr_rddata <= address_q;
                    OFF_RDDATA:  csr_rddata <= rddata_q;
                    OFF_WRDATA:  csr_rddata <= wrdata_q;
                    default:     csr_rddata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hssi_tc_mailbox_resp.sv
// ---------------------------------------------------------------------------
// tb_hssi_tc_mailbox_resp
//   Directed bench for the traffic-controller mailbox. Inputs change on the
//   falling clock edge; the bus monitor samples on the rising edge.
// ---------------------------------------------------------------------------
module tb_hssi_tc_mailbox_resp;
    import hssi_tc_mailbox_resp_pkg::*;

    localparam int TC_ADDR_W      = 16;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_wr, csr_rd;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wrdata;
    logic [31:0] csr_rddata;
    logic        csr_rdvalid;

    hssi_tc_mailbox_resp_if #(.TC_ADDR_W(TC_ADDR_W)) tc ();

    hssi_tc_mailbox_resp #(
        .TC_ADDR_W      (TC_ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_wr      (csr_wr),
        .csr_rd      (csr_rd),
        .csr_addr    (csr_addr),
        .csr_wrdata  (csr_wrdata),
        .csr_rddata  (csr_rddata),
        .csr_rdvalid (csr_rdvalid),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor: strobe-high cycles, accepted accesses, last accepted
    // address/data, and address/data changes while a write is stalled.
    int          wr_hi = 0, rd_hi = 0, wr_acc = 0, rd_acc = 0, unstable = 0;
    logic [31:0] last_addr = '0, last_wrdata = '0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(posedge clk) begin
        if (tc.tc_wr) begin
            wr_hi++;
            if (prev_wr && (32'(tc.tc_addr) != prev_addr || tc.tc_wrdata != prev_data))
                unstable++;
            if (!tc.tc_waitrequest) begin
                wr_acc++;
                last_addr   = 32'(tc.tc_addr);
                last_wrdata = tc.tc_wrdata;
            end
        end
        if (tc.tc_rd) begin
            rd_hi++;
            if (!tc.tc_waitrequest) begin
                rd_acc++;
                last_addr = 32'(tc.tc_addr);
            end
        end
        prev_wr   = tc.tc_wr;
        prev_addr = 32'(tc.tc_addr);
        prev_data = tc.tc_wrdata;
    end

    int b_wr_hi, b_rd_hi, b_wr_acc, b_rd_acc;

    task automatic snap();
        b_wr_hi  = wr_hi;
        b_rd_hi  = rd_hi;
        b_wr_acc = wr_acc;
        b_rd_acc = rd_acc;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Both CSR tasks are entered on a falling edge and return on the next one.
    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_wr     = 1'b1;
        csr_addr   = a;
        csr_wrdata = d;
        @(negedge clk);
        csr_wr     = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        csr_rd   = 1'b1;
        csr_addr = a;
        @(negedge clk);
        csr_rd   = 1'b0;
        d        = csr_rddata;
        v        = csr_rdvalid;
    endtask

    task automatic wait_idle(input int max_reads);
        logic [31:0] d;
        logic        v;
        int          n;
        n = 0;
        do begin
            csr_read(OFF_CMD, d, v);
            n++;
        end while (d[STAT_BUSY_BIT] && n < max_reads);
        check("wait_idle_busy", 32'(d[STAT_BUSY_BIT]), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        v;

        rst_n                 = 1'b0;
        csr_wr                = 1'b0;
        csr_rd                = 1'b0;
        csr_addr              = '0;
        csr_wrdata            = '0;
        tc.tc_waitrequest     = 1'b0;
        tc.tc_rddata          = '0;
        tc.tc_rddata_valid    = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_tc_rd",    32'(tc.tc_rd),      32'h0);
        check("rst_tc_wr",    32'(tc.tc_wr),      32'h0);
        check("rst_tc_addr",  32'(tc.tc_addr),    32'h0);
        check("rst_rdvalid",  32'(csr_rdvalid),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        csr_read(OFF_CMD, d, v);
        check("rst_cmd", d, 32'h0);
        check("rst_cmd_rdvalid", 32'(v), 32'h1);
        csr_read(OFF_ADDRESS, d, v);
        check("rst_address", d, 32'h0);
        csr_read(OFF_RDDATA, d, v);
        check("rst_rddata", d, 32'h0);

        // ---------------- simple write ----------------
        csr_write(OFF_ADDRESS, 32'h0000_0000);
        csr_write(OFF_WRDATA,  32'h0000_0010);
        snap();
        csr_write(OFF_CMD, 32'h2);
        check("wr_strobe",    32'(tc.tc_wr),   32'h1);
        check("wr_tc_addr",   32'(tc.tc_addr), 32'h0);
        check("wr_tc_wrdata", tc.tc_wrdata,    32'h10);
        csr_read(OFF_CMD, d, v);
        check("wr_busy_1", d, 32'h0A);      // busy | cmd WR
        csr_read(OFF_CMD, d, v);
        check("wr_busy_2", d, 32'h0A);      // still in DONE
        csr_read(OFF_CMD, d, v);
        check("wr_ack",    d, 32'h06);      // ack | cmd WR
        check("wr_hi_cycles", 32'(wr_hi - b_wr_hi),   32'd1);
        check("wr_accepts",   32'(wr_acc - b_wr_acc), 32'd1);
        check("wr_last_data", last_wrdata, 32'h10);
        check("wr_strobe_off", 32'(tc.tc_wr), 32'h0);

        // ---------------- read with late response ----------------
        tc.tc_rddata       = 32'hBAD0_BAD0;
        tc.tc_rddata_valid = 1'b1;          // stray valid in IDLE
        @(negedge clk);
        tc.tc_rddata_valid = 1'b0;
        csr_read(OFF_RDDATA, d, v);
        check("stray_valid_ignored", d, 32'h0);

        csr_write(OFF_ADDRESS, 32'h0000_0101);
        snap();
        csr_write(OFF_CMD, 32'h1);
        check("rd_strobe",  32'(tc.tc_rd),   32'h1);
        check("rd_tc_addr", 32'(tc.tc_addr), 32'h101);
        @(negedge clk);                     // request accepted
        @(negedge clk);
        tc.tc_rddata       = 32'h0000_0010;
        tc.tc_rddata_valid = 1'b1;
        @(negedge clk);
        tc.tc_rddata_valid = 1'b0;
        tc.tc_rddata       = 32'h0;
        wait_idle(10);
        csr_read(OFF_RDDATA, d, v);
        check("rd_rddata", d, 32'h10);
        csr_read(OFF_CMD, d, v);
        check("rd_cmd", d, 32'h05);
        check("rd_accepts", 32'(rd_acc - b_rd_acc), 32'd1);
        check("rd_hi_cycles", 32'(rd_hi - b_rd_hi), 32'd1);

        // ---------------- write stalled by waitrequest ----------------
        csr_write(OFF_ADDRESS, 32'h0000_0200);
        csr_write(OFF_WRDATA,  32'h0000_0001);
        tc.tc_waitrequest = 1'b1;
        snap();
        csr_write(OFF_CMD, 32'h2);
        repeat (3) @(negedge clk);
        check("stall_strobe_held", 32'(tc.tc_wr), 32'h1);
        tc.tc_waitrequest = 1'b0;
        wait_idle(10);
        check("stall_hi_cycles", 32'(wr_hi - b_wr_hi),   32'd4);
        check("stall_accepts",   32'(wr_acc - b_wr_acc), 32'd1);
        check("stall_stable",    32'(unstable),          32'd0);
        check("stall_last_addr", last_addr,   32'h200);
        check("stall_last_data", last_wrdata, 32'h1);
        csr_read(OFF_CMD, d, v);
        check("stall_cmd", d, 32'h06);

        // ---------------- read timeout ----------------
        csr_write(OFF_ADDRESS, 32'h0000_0101);
        snap();
        csr_write(OFF_CMD, 32'h1);
        repeat (16) @(negedge clk);
        csr_read(OFF_CMD, d, v);
        check("to_not_yet",  d, 32'h09);    // counter at its last value
        csr_read(OFF_CMD, d, v);
        check("to_err_done", d, 32'h19);    // err set, DONE still busy
        csr_read(OFF_CMD, d, v);
        check("to_cmd",      d, 32'h15);
        check("to_rd_off",   32'(tc.tc_rd), 32'h0);
        check("to_rd_hi",    32'(rd_hi - b_rd_hi), 32'd1);
        csr_read(OFF_RDDATA, d, v);
        check("to_rddata",   d, 32'hDEAD_BEEF);

        // ---------------- illegal command, NOOP ----------------
        snap();
        csr_write(OFF_CMD, 32'h3);
        csr_read(OFF_CMD, d, v);
        check("ill_cmd",   d, 32'h17);
        check("ill_no_wr", 32'(wr_hi - b_wr_hi), 32'd0);
        check("ill_no_rd", 32'(rd_hi - b_rd_hi), 32'd0);
        csr_write(OFF_CMD, 32'h0);
        csr_read(OFF_CMD, d, v);
        check("noop_clears_status", d & 32'h1C, 32'h0);

        // ---------------- writes ignored while busy ----------------
        csr_write(OFF_ADDRESS, 32'h0000_00AA);
        csr_write(OFF_WRDATA,  32'h0000_0077);
        tc.tc_waitrequest = 1'b1;
        snap();
        csr_write(OFF_CMD, 32'h2);
        csr_write(OFF_CMD, 32'h2);
        csr_write(OFF_ADDRESS, 32'h0000_0055);
        csr_write(OFF_WRDATA,  32'h0000_0099);
        csr_write(OFF_CMD, 32'h1);
        tc.tc_waitrequest = 1'b0;
        wait_idle(10);
        repeat (4) @(negedge clk);
        check("busy_one_access", 32'(wr_acc - b_wr_acc), 32'd1);
        check("busy_no_rd",      32'(rd_hi - b_rd_hi),   32'd0);
        check("busy_last_addr",  last_addr, 32'hAA);
        csr_read(OFF_ADDRESS, d, v);
        check("busy_address", d, 32'hAA);
        csr_read(OFF_WRDATA, d, v);
        check("busy_wrdata",  d, 32'h77);
        csr_read(OFF_CMD, d, v);
        check("busy_cmd",     d, 32'h06);

        // ---------------- RDDATA read-only, unmapped offset ----------------
        csr_write(OFF_RDDATA, 32'h1234_5678);
        csr_read(OFF_RDDATA, d, v);
        check("rddata_ro", d, 32'hDEAD_BEEF);
        csr_read(4'h6, d, v);
        check("unmapped_data",  d, 32'h0);
        check("unmapped_valid", 32'(v), 32'h1);
        @(negedge clk);
        check("rdvalid_idle", 32'(csr_rdvalid), 32'h0);

        // ---------------- reset during RD_WAIT ----------------
        csr_write(OFF_CMD, 32'h1);
        @(negedge clk);                     // now waiting for read data
        rst_n = 1'b0;
        #1;
        check("arst_state",   32'(dut.state_q), 32'(ST_IDLE));
        check("arst_rddata",  csr_rddata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tc.tc_rddata       = 32'hCAFE_F00D;
        tc.tc_rddata_valid = 1'b1;          // response that arrives too late
        @(negedge clk);
        tc.tc_rddata_valid = 1'b0;
        csr_read(OFF_CMD, d, v);
        check("arst_cmd", d, 32'h0);
        csr_read(OFF_ADDRESS, d, v);
        check("arst_address", d, 32'h0);
        csr_read(OFF_WRDATA, d, v);
        check("arst_wrdata", d, 32'h0);
        csr_read(OFF_RDDATA, d, v);
        check("arst_rddata_reg", d, 32'h0);
        check("arst_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("arst_tc_rd", 32'(tc.tc_rd), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
